dds_ctrl_mc: RTL and testbench
==============================

Name: dds_ctrl_mc

Overview:
Parametrised multi-channel successor to the single-channel DDS controller. It holds one shared waveform RAM, loaded and read back through the register interface. On a start request it plays the table for a programmed number of cycles, or continuously, across NCH phase-offset channels. Each channel produces a forward sample (table[addr]) and a backward/mirrored sample (table[~addr]) every cycle. It sits between the register block and the DAC formatting logic.

Parameters:
ADDR_W, 10, phase/table address width; table depth = 2^ADDR_W.
DATA_W, 14, sample width.
NCH, 2, number of output channels (1..8).
TIME_W, 32, run-length counter width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
reg_dds_inc  in  ADDR_W  phase increment per cycle, latched at start
reg_ch_offset  in  ADDR_W  phase spacing between adjacent channels, latched at start
reg_dds_time  in  TIME_W  run length in cycles, latched at start
reg_dds_mode  in  1  0 = single run of reg_dds_time cycles; 1 = continuous until dds_stop
dds_addr  in  ADDR_W  start phase of channel 0
dds_req  in  1  start pulse
dds_stop  in  1  stop pulse
dds_ack  out  1  one-cycle start acknowledge
dds_valid  out  1  sample outputs valid
dds_done  out  1  one-cycle end-of-run pulse
dds_data_forward  out  NCH*DATA_W  channel k at [k*DATA_W +: DATA_W]
dds_data_backward  out  NCH*DATA_W  mirrored samples, same packing
reg_ram_cfg_en  in  1  config mode; RAM port enabled, starts blocked
reg_ram_whrl  in  1  1 = write, 0 = read
reg_ram_addr  in  ADDR_W  RAM config address
reg_ram_wdata  in  DATA_W  RAM write data
reg_ram_req  in  1  RAM access pulse
reg_ram_rdata  out  DATA_W  read data, valid with ram_done
ram_done  out  1  one-cycle access complete
ram_err  out  1  one-cycle pulse with ram_done when the access was rejected

Behaviour:
- Reset: all outputs 0, FSM = IDLE, phase and counter 0. RAM contents are not cleared; they are retained across rst.
- FSM states: IDLE, RUN.
- IDLE, dds_req=1 and reg_ram_cfg_en=0:
  - latch phase<=dds_addr, plus inc, offset, time and mode;
  - dds_ack=1 on the next cycle;
  - go to RUN, except single mode with time=0: return to IDLE and pulse dds_done together with dds_ack, with no valid cycles.
- dds_req while reg_ram_cfg_en=1, or while in RUN: ignored, no ack.
- RUN, each cycle:
  - channel address a_k = phase + k*offset, mod 2^ADDR_W;
  - forward_k = ram[a_k], backward_k = ram[(2^ADDR_W-1) - a_k];
  - phase <= phase + inc, wrapping mod 2^ADDR_W with the carry dropped;
  - counter increments.
- Output latency: samples are registered, 1 cycle after the address. dds_valid is high exactly for the cycles carrying addressed samples.
  - Single mode: dds_valid is high for exactly reg_dds_time cycles; the first valid cycle is the cycle after dds_ack.
  - Single mode: dds_done pulses in the cycle after the last valid sample, then FSM = IDLE.
- Continuous mode: the counter is ignored and may wrap. dds_stop pulse: the current cycle is the last address issued, then done behaves as in single mode.
- dds_stop in single mode: early termination with the same timing as continuous-mode stop. dds_stop in IDLE: ignored.
- Data outputs hold their last value when dds_valid=0.
- RAM port:
  - reg_ram_req is accepted only with reg_ram_cfg_en=1 and FSM=IDLE.
  - Write: ram[addr]<=wdata.
  - Read: reg_ram_rdata<=ram[addr].
  - ram_done=1 on the cycle after the request.
  - Rejected request (cfg_en=0 or RUN): ram_done=1 and ram_err=1 on the next cycle, RAM unchanged, rdata unchanged.
- Simultaneous dds_req and reg_ram_req in IDLE with cfg_en=1: RAM access proceeds; dds_req is ignored.
- rst asserted mid-run: immediate return to the reset state; no dds_done is produced.
- Back-to-back: a dds_req in the same cycle as dds_done is ignored; a new run needs dds_req while in IDLE.

Test Plan:
- RAM load/readback: cfg_en=1; write ram[i]=i*3 for i=0..1023; read addresses 0, 5 and 1023 -> rdata 0, 15, 3069, each with ram_done one cycle after its req and ram_err=0.
- Single run, NCH=2: dds_addr=6, inc=10, offset=100, time=100 -> dds_ack, then exactly 100 valid cycles.
  - First cycle: ch0 fwd=18, ch1 fwd=318, ch0 bwd=ram[1017]=3051.
  - Second cycle: ch0 fwd=48.
  - dds_done one cycle after the last valid cycle.
- Wrap-around: dds_addr=1020, inc=10 -> ch0 addresses 1020, 6, 16, giving fwd 3060, 18, 48.
- Continuous mode: mode=1, time=5, dds_stop asserted after 300 valid cycles -> valid is not truncated at 5; valid ends and dds_done pulses exactly as specified.
- Blocking: reg_ram_req during RUN -> ram_done and ram_err pulse, RAM unchanged. dds_req with cfg_en=1 -> no ack. Single mode with time=0 -> ack and done in the same cycle, valid never asserted.
- Reset mid-run: assert rst 20 cycles into a run -> all outputs 0 immediately, no done pulse; a subsequent start works; RAM readback still returns i*3.

Source files
------------

// File: rtl/dds_ctrl_mc.sv
// Purpose: multi-channel DDS player over one shared waveform RAM, plus a RAM load/readback port.
// Latency: samples registered 1 cycle after address issue; ack/done/ram_done are registered 1-cycle pulses.
// Backpressure: none; requests that arrive while busy or in the wrong mode are dropped (RAM ones flagged by ram_err).
module dds_ctrl_mc #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14,
    parameter int NCH    = 2,
    parameter int TIME_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     reg_dds_inc,
    input  logic [ADDR_W-1:0]     reg_ch_offset,
    input  logic [TIME_W-1:0]     reg_dds_time,
    input  logic                  reg_dds_mode,
    input  logic [ADDR_W-1:0]     dds_addr,
    input  logic                  dds_req,
    input  logic                  dds_stop,
    output logic                  dds_ack,
    output logic                  dds_valid,
    output logic                  dds_done,
    output logic [NCH*DATA_W-1:0] dds_data_forward,
    output logic [NCH*DATA_W-1:0] dds_data_backward,
    input  logic                  reg_ram_cfg_en,
    input  logic                  reg_ram_whrl,
    input  logic [ADDR_W-1:0]     reg_ram_addr,
    input  logic [DATA_W-1:0]     reg_ram_wdata,
    input  logic                  reg_ram_req,
    output logic [DATA_W-1:0]     reg_ram_rdata,
    output logic                  ram_done,
    output logic                  ram_err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   ram [DEPTH];
    logic [ADDR_W-1:0]   phase, inc_r, offset_r;
    logic [TIME_W-1:0]   time_r, cnt;
    logic                mode_r;
    logic                issuing;   // RUN splits into issuing addresses, then draining the sample pipe
    logic                last_d1;   // last address was issued one cycle ago
    logic                start, zero_run, issue, last_issue, ram_acc;
    logic [NCH*DATA_W-1:0] fwd_nxt, bwd_nxt;

    // Request qualification; a start is refused in a done cycle so back-to-back needs a fresh req in IDLE
    always_comb begin
        start      = (state == IDLE) && dds_req && !reg_ram_cfg_en && !dds_done;
        zero_run   = !reg_dds_mode && (reg_dds_time == '0);
        issue      = (state == RUN) && issuing;
        last_issue = issue && (dds_stop || (!mode_r && (cnt == time_r - TIME_W'(1))));
        ram_acc    = reg_ram_req && reg_ram_cfg_en && (state == IDLE);
    end

    // Per-channel phase-offset addresses and the forward/mirrored table lookups
    always_comb begin
        fwd_nxt = '0;
        bwd_nxt = '0;
        for (int k = 0; k < NCH; k++) begin
            logic [ADDR_W-1:0] a;
            a = phase + ADDR_W'(k) * offset_r;
            fwd_nxt[k*DATA_W +: DATA_W] = ram[a];
            bwd_nxt[k*DATA_W +: DATA_W] = ram[~a];
        end
    end

    // Next state: stay in RUN until the done pulse has been emitted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !zero_run) state_nxt = RUN;
            RUN:     if (dds_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, run parameters, sample pipeline and RAM-port handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            phase             <= '0;
            inc_r             <= '0;
            offset_r          <= '0;
            time_r            <= '0;
            mode_r            <= 1'b0;
            cnt               <= '0;
            issuing           <= 1'b0;
            last_d1           <= 1'b0;
            dds_ack           <= 1'b0;
            dds_valid         <= 1'b0;
            dds_done          <= 1'b0;
            dds_data_forward  <= '0;
            dds_data_backward <= '0;
            reg_ram_rdata     <= '0;
            ram_done          <= 1'b0;
            ram_err           <= 1'b0;
        end else begin
            state     <= state_nxt;
            dds_ack   <= start;
            dds_valid <= issue;
            last_d1   <= last_issue;
            // zero-length single run finishes in the ack cycle without ever issuing
            dds_done  <= last_d1 || (start && zero_run);
            if (start) begin
                phase    <= dds_addr;
                inc_r    <= reg_dds_inc;
                offset_r <= reg_ch_offset;
                time_r   <= reg_dds_time;
                mode_r   <= reg_dds_mode;
                cnt      <= '0;
                issuing  <= !zero_run;
            end else if (issue) begin
                phase <= phase + inc_r;
                cnt   <= cnt + TIME_W'(1);
                if (last_issue) issuing <= 1'b0;
            end
            if (issue) begin
                dds_data_forward  <= fwd_nxt;
                dds_data_backward <= bwd_nxt;
            end
            ram_done <= reg_ram_req;
            ram_err  <= reg_ram_req && !ram_acc;
            if (ram_acc && !reg_ram_whrl) reg_ram_rdata <= ram[reg_ram_addr];
        end
    end

    // Table storage is deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (ram_acc && reg_ram_whrl) ram[reg_ram_addr] <= reg_ram_wdata;
    end
endmodule

// File: tb/tb_dds_ctrl_mc.sv
// Bench for dds_ctrl_mc: randomized runs and RAM traffic checked against an array/arithmetic model.
// Drives inputs and samples outputs 1 time unit after each rising clock edge.
// Every scenario task compares inline and bumps checks/errors.
module tb_dds_ctrl_mc;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 14;
    localparam int NCH    = 2;
    localparam int TIME_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                  clk, rst;
    logic [ADDR_W-1:0]     reg_dds_inc, reg_ch_offset, dds_addr, reg_ram_addr;
    logic [TIME_W-1:0]     reg_dds_time;
    logic                  reg_dds_mode, dds_req, dds_stop;
    logic                  dds_ack, dds_valid, dds_done;
    logic [NCH*DATA_W-1:0] dds_data_forward, dds_data_backward;
    logic                  reg_ram_cfg_en, reg_ram_whrl, reg_ram_req;
    logic [DATA_W-1:0]     reg_ram_wdata, reg_ram_rdata;
    logic                  ram_done, ram_err;

    int checks = 0;
    int errors = 0;
    int model [DEPTH];

    dds_ctrl_mc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH), .TIME_W(TIME_W)) dut (
        .clk(clk), .rst(rst),
        .reg_dds_inc(reg_dds_inc), .reg_ch_offset(reg_ch_offset), .reg_dds_time(reg_dds_time),
        .reg_dds_mode(reg_dds_mode), .dds_addr(dds_addr), .dds_req(dds_req), .dds_stop(dds_stop),
        .dds_ack(dds_ack), .dds_valid(dds_valid), .dds_done(dds_done),
        .dds_data_forward(dds_data_forward), .dds_data_backward(dds_data_backward),
        .reg_ram_cfg_en(reg_ram_cfg_en), .reg_ram_whrl(reg_ram_whrl), .reg_ram_addr(reg_ram_addr),
        .reg_ram_wdata(reg_ram_wdata), .reg_ram_req(reg_ram_req), .reg_ram_rdata(reg_ram_rdata),
        .ram_done(ram_done), .ram_err(ram_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Expected sample bus for sample j of a run: channel k reads phase (base + j*inc + k*off) mod depth
    function automatic logic [NCH*DATA_W-1:0] exp_bus(input int base, input int inc, input int off,
                                                      input int j, input bit bwd);
        logic [NCH*DATA_W-1:0] b;
        int a;
        b = '0;
        for (int k = 0; k < NCH; k++) begin
            a = (base + j * inc + k * off) % DEPTH;
            if (bwd) a = DEPTH - 1 - a;
            b[k*DATA_W +: DATA_W] = DATA_W'(model[a]);
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_access(input logic wr, input int addr, input int wdata, input logic cfg);
        reg_ram_cfg_en = cfg;
        reg_ram_whrl   = wr;
        reg_ram_addr   = ADDR_W'(addr);
        reg_ram_wdata  = DATA_W'(wdata);
        reg_ram_req    = 1'b1;
        step();
        reg_ram_req    = 1'b0;
    endtask

    // Starts a run and follows it cycle by cycle; cycle 1 is the ack cycle (and the first address cycle)
    task automatic run_and_check(input string name, input int base, input int inc, input int off,
                                 input int tim, input logic mode, input int stop_at, input int inj_at,
                                 input logic b2b,
                                 output logic [NCH*DATA_W-1:0] s0f, output logic [NCH*DATA_W-1:0] s1f,
                                 output logic [NCH*DATA_W-1:0] s2f, output logic [NCH*DATA_W-1:0] s0b);
        int n, j, inj_addr;
        logic ev, ed;
        logic [NCH*DATA_W-1:0] ef, eb, last_f;
        if (mode) n = stop_at;
        else if (stop_at > 0 && stop_at < tim) n = stop_at;
        else n = tim;
        s0f = '0; s1f = '0; s2f = '0; s0b = '0;
        last_f   = (n > 0) ? exp_bus(base, inc, off, n - 1, 1'b0) : dds_data_forward;
        inj_addr = $urandom_range(0, DEPTH - 1);
        reg_ram_cfg_en = 1'b0;
        dds_addr       = ADDR_W'(base);
        reg_dds_inc    = ADDR_W'(inc);
        reg_ch_offset  = ADDR_W'(off);
        reg_dds_time   = TIME_W'(tim);
        reg_dds_mode   = mode;
        dds_req        = 1'b1;
        step();
        for (int c = 1; c <= n + 4; c++) begin
            if (c > 1) step();
            dds_req     = 1'b0;
            reg_ram_req = 1'b0;
            dds_stop    = (c == stop_at);
            if (c == inj_at) begin
                reg_ram_cfg_en = 1'b1;
                reg_ram_whrl   = 1'b1;
                reg_ram_addr   = ADDR_W'(inj_addr);
                reg_ram_wdata  = ~DATA_W'(model[inj_addr]);
                reg_ram_req    = 1'b1;
                dds_req        = 1'b1;
            end
            if (inj_at > 0 && c == inj_at + 1) begin
                reg_ram_cfg_en = 1'b0;
                checks++;
                if (ram_done !== 1'b1 || ram_err !== 1'b1) begin
                    errors++;
                    $display("FAIL %s run_ram_reject: done/err got %b%b want 11", name, ram_done, ram_err);
                end
            end
            checks++;
            if (dds_ack !== (c == 1)) begin
                errors++;
                $display("FAIL %s ack c=%0d got %b want %b", name, c, dds_ack, (c == 1));
            end
            ev = (c >= 2) && (c <= n + 1);
            checks++;
            if (dds_valid !== ev) begin
                errors++;
                $display("FAIL %s valid c=%0d got %b want %b", name, c, dds_valid, ev);
            end
            if (ev) begin
                j  = c - 2;
                ef = exp_bus(base, inc, off, j, 1'b0);
                eb = exp_bus(base, inc, off, j, 1'b1);
                if (j == 0) begin s0f = dds_data_forward; s0b = dds_data_backward; end
                if (j == 1) s1f = dds_data_forward;
                if (j == 2) s2f = dds_data_forward;
                checks++;
                if (dds_data_forward !== ef || dds_data_backward !== eb) begin
                    errors++;
                    $display("FAIL %s sample j=%0d got fwd %h bwd %h want fwd %h bwd %h",
                             name, j, dds_data_forward, dds_data_backward, ef, eb);
                end
            end
            ed = (n == 0) ? (c == 1) : (c == n + 2);
            checks++;
            if (dds_done !== ed) begin
                errors++;
                $display("FAIL %s done c=%0d got %b want %b", name, c, dds_done, ed);
            end
            if (n > 0 && c >= n + 2) begin
                checks++;
                if (dds_data_forward !== last_f) begin
                    errors++;
                    $display("FAIL %s hold c=%0d got %h want %h", name, c, dds_data_forward, last_f);
                end
            end
            if (b2b && ed) dds_req = 1'b1;
        end
        dds_req  = 1'b0;
        dds_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dds_req = 0; dds_stop = 0; reg_dds_mode = 0; reg_dds_time = '0; reg_dds_inc = '0;
        reg_ch_offset = '0; dds_addr = '0; reg_ram_cfg_en = 0; reg_ram_whrl = 0;
        reg_ram_addr = '0; reg_ram_wdata = '0; reg_ram_req = 0;
        step(); step();
        checks++;
        if ({dds_ack, dds_valid, dds_done, ram_done, ram_err} !== 5'b0 ||
            dds_data_forward !== '0 || dds_data_backward !== '0 || reg_ram_rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: got ack/valid/done/rd/err %b%b%b%b%b fwd %h bwd %h rdata %h want all 0",
                     dds_ack, dds_valid, dds_done, ram_done, ram_err, dds_data_forward,
                     dds_data_backward, reg_ram_rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_ram_load();
        int addrs [3] = '{0, 5, 1023};
        int wants [3] = '{0, 15, 3069};
        int a;
        logic [DATA_W-1:0] prev;
        for (int i = 0; i < DEPTH; i++) begin
            ram_access(1'b1, i, i * 3, 1'b1);
            model[i] = i * 3;
            checks++;
            if (ram_done !== 1'b1 || ram_err !== 1'b0) begin
                errors++;
                $display("FAIL ram_write i=%0d done/err got %b%b want 10", i, ram_done, ram_err);
            end
        end
        for (int i = 0; i < 3; i++) begin
            ram_access(1'b0, addrs[i], 0, 1'b1);
            checks++;
            if (ram_done !== 1'b1 || ram_err !== 1'b0 || reg_ram_rdata !== DATA_W'(wants[i])) begin
                errors++;
                $display("FAIL ram_read a=%0d got done %b err %b rdata %0d want 1 0 %0d",
                         addrs[i], ram_done, ram_err, reg_ram_rdata, wants[i]);
            end
        end
        step();
        checks++;
        if (ram_done !== 1'b0) begin
            errors++;
            $display("FAIL ram_done_pulse got %b want 0", ram_done);
        end
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, DEPTH - 1);
            ram_access(1'b0, a, 0, 1'b1);
            checks++;
            if (reg_ram_rdata !== DATA_W'(model[a])) begin
                errors++;
                $display("FAIL ram_rand_read a=%0d got %0d want %0d", a, reg_ram_rdata, model[a]);
            end
        end
        prev = reg_ram_rdata;
        ram_access(1'b1, 7, 999, 1'b0);
        checks++;
        if (ram_done !== 1'b1 || ram_err !== 1'b1 || reg_ram_rdata !== prev) begin
            errors++;
            $display("FAIL ram_cfg_off_reject got done %b err %b rdata %0d want 1 1 %0d",
                     ram_done, ram_err, reg_ram_rdata, prev);
        end
        ram_access(1'b0, 7, 0, 1'b1);
        checks++;
        if (reg_ram_rdata !== DATA_W'(21)) begin
            errors++;
            $display("FAIL ram_unchanged a=7 got %0d want 21", reg_ram_rdata);
        end
        reg_ram_cfg_en = 1'b0;
        step();
    endtask

    task automatic test_single_run();
        logic [NCH*DATA_W-1:0] s0f, s1f, s2f, s0b;
        run_and_check("single", 6, 10, 100, 100, 1'b0, 0, 0, 1'b0, s0f, s1f, s2f, s0b);
        checks++;
        if (s0f[DATA_W-1:0] !== 14'd18 || s0f[2*DATA_W-1:DATA_W] !== 14'd318 ||
            s0b[DATA_W-1:0] !== 14'd3051 || s1f[DATA_W-1:0] !== 14'd48) begin
            errors++;
            $display("FAIL single_points got ch0 %0d ch1 %0d bwd0 %0d next %0d want 18 318 3051 48",
                     s0f[DATA_W-1:0], s0f[2*DATA_W-1:DATA_W], s0b[DATA_W-1:0], s1f[DATA_W-1:0]);
        end
    endtask

    task automatic test_wrap();
        logic [NCH*DATA_W-1:0] s0f, s1f, s2f, s0b;
        run_and_check("wrap", 1020, 10, 3, 5, 1'b0, 0, 0, 1'b0, s0f, s1f, s2f, s0b);
        checks++;
        if (s0f[DATA_W-1:0] !== 14'd3060 || s1f[DATA_W-1:0] !== 14'd18 || s2f[DATA_W-1:0] !== 14'd48) begin
            errors++;
            $display("FAIL wrap_points got %0d %0d %0d want 3060 18 48",
                     s0f[DATA_W-1:0], s1f[DATA_W-1:0], s2f[DATA_W-1:0]);
        end
    endtask

    task automatic test_continuous();
        logic [NCH*DATA_W-1:0] s0f, s1f, s2f, s0b;
        run_and_check("cont", 100, 7, 512, 5, 1'b1, 301, 0, 1'b0, s0f, s1f, s2f, s0b);
        run_and_check("single_stop", 40, 3, 1, 50, 1'b0, 10, 0, 1'b0, s0f, s1f, s2f, s0b);
    endtask

    task automatic test_blocking();
        logic [NCH*DATA_W-1:0] s0f, s1f, s2f, s0b;
        run_and_check("run_block", 200, 13, 77, 20, 1'b0, 0, 5, 1'b0, s0f, s1f, s2f, s0b);
        for (int a = 0; a < 4; a++) begin
            ram_access(1'b0, a * 300, 0, 1'b1);
            checks++;
            if (reg_ram_rdata !== DATA_W'(model[a * 300])) begin
                errors++;
                $display("FAIL ram_after_run a=%0d got %0d want %0d", a * 300, reg_ram_rdata, model[a * 300]);
            end
        end
        dds_req = 1'b1;
        step();
        dds_req = 1'b0;
        checks++;
        if (dds_ack !== 1'b0) begin
            errors++;
            $display("FAIL req_cfg_en ack got %b want 0", dds_ack);
        end
        step();
        checks++;
        if (dds_ack !== 1'b0 || dds_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_cfg_en later ack/valid got %b%b want 00", dds_ack, dds_valid);
        end
        dds_req = 1'b1;
        ram_access(1'b0, 5, 0, 1'b1);
        dds_req = 1'b0;
        checks++;
        if (ram_done !== 1'b1 || ram_err !== 1'b0 || reg_ram_rdata !== DATA_W'(model[5]) || dds_ack !== 1'b0) begin
            errors++;
            $display("FAIL simul_req got done %b err %b rdata %0d ack %b want 1 0 %0d 0",
                     ram_done, ram_err, reg_ram_rdata, dds_ack, model[5]);
        end
        reg_ram_cfg_en = 1'b0;
        step();
        run_and_check("zero_time", 9, 1, 1, 0, 1'b0, 0, 0, 1'b0, s0f, s1f, s2f, s0b);
        run_and_check("back_to_back", 500, 31, 64, 8, 1'b0, 0, 0, 1'b1, s0f, s1f, s2f, s0b);
        run_and_check("zero_b2b", 3, 1, 1, 0, 1'b0, 0, 0, 1'b1, s0f, s1f, s2f, s0b);
    endtask

    task automatic test_reset_mid_run();
        logic [NCH*DATA_W-1:0] s0f, s1f, s2f, s0b;
        dds_addr = 10'd50; reg_dds_inc = 10'd9; reg_ch_offset = 10'd200;
        reg_dds_time = 32'd5; reg_dds_mode = 1'b1; reg_ram_cfg_en = 1'b0;
        dds_req = 1'b1;
        step();
        dds_req = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({dds_ack, dds_valid, dds_done, ram_done, ram_err} !== 5'b0 ||
            dds_data_forward !== '0 || dds_data_backward !== '0 || reg_ram_rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got flags %b%b%b%b%b fwd %h bwd %h rdata %h want all 0",
                     dds_ack, dds_valid, dds_done, ram_done, ram_err, dds_data_forward,
                     dds_data_backward, reg_ram_rdata);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst = 1'b0;
            step();
            checks++;
            if (dds_done !== 1'b0 || dds_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done i=%0d done/valid got %b%b want 00", i, dds_done, dds_valid);
            end
        end
        run_and_check("after_reset", 1000, 50, 20, 12, 1'b0, 0, 0, 1'b0, s0f, s1f, s2f, s0b);
        for (int i = 0; i < 3; i++) begin
            ram_access(1'b0, i * 511, 0, 1'b1);
            checks++;
            if (reg_ram_rdata !== DATA_W'(i * 511 * 3)) begin
                errors++;
                $display("FAIL ram_kept a=%0d got %0d want %0d", i * 511, reg_ram_rdata, i * 511 * 3);
            end
        end
        reg_ram_cfg_en = 1'b0;
        step();
    endtask

    task automatic test_random_runs();
        logic [NCH*DATA_W-1:0] s0f, s1f, s2f, s0b;
        int a, d, tim, stop_at;
        logic mode;
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 16; w++) begin
                a = $urandom_range(0, DEPTH - 1);
                d = $urandom_range(0, (1 << DATA_W) - 1);
                ram_access(1'b1, a, d, 1'b1);
                model[a] = d;
            end
            reg_ram_cfg_en = 1'b0;
            step();
            mode = 1'($urandom_range(0, 1));
            tim  = $urandom_range(1, 40);
            if (mode) stop_at = $urandom_range(1, 60);
            else stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
            run_and_check("random", $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                          $urandom_range(0, DEPTH - 1), tim, mode, stop_at,
                          ($urandom_range(0, 1) == 1) ? 2 : 0, 1'($urandom_range(0, 1)),
                          s0f, s1f, s2f, s0b);
        end
    endtask

    initial begin
        test_reset();
        test_ram_load();
        test_single_run();
        test_wrap();
        test_continuous();
        test_blocking();
        test_reset_mid_run();
        test_random_runs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
